clk_div_bank: RTL and testbench

Multi-channel programmable clock divider: the parametrised successor of the fixed single-output 1 Hz divider. It generates NUM_CH independent divided square-wave outputs plus matching single-cycle tick enables from CLK. Each channel's half-period is reloaded at run time through a simple write port, and updates take effect glitch-free at the channel's next terminal count. It sits at the top of the board design and feeds display scan, debounce and timebase logic.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_channel.sv | 74 +++++++
 rtl/clk_div_bank.sv | 49 ++++
 tb/tb_clk_div_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank programmable divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef logic [CNT_W_DEFAULT-1:0] half_t;

  // Width of a channel index; a single-channel bank still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter with active/shadow reload and registered outputs.
// The phase-restart input exists only when DIVBANK_SYNC_EN is defined.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W        = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = '1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
`ifdef DIVBANK_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic             restart;
  logic             term;
  logic             apply;

`ifdef DIVBANK_SYNC_EN
  assign restart = sync;
`else
  assign restart = 1'b0;
`endif

  assign term  = en && (cnt == active);
  // The shadow may only replace active while the counter is being cleared.
  assign apply = pending && (restart || !en || term);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      active  <= DEFAULT_HALF;
      shadow  <= DEFAULT_HALF;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (restart || !en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (term) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
      end else begin
        cnt     <= cnt + 1'b1;
        tick    <= 1'b0;
      end

      if (apply) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      // NOTE: the later assignment wins, so a same-cycle write re-arms pending after an apply.
      if (wr) begin
        shadow  <= wr_half;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider with glitch-free half-period reload.
// Optional global phase restart (SYNC port) when DIVBANK_SYNC_EN is defined.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_HALF = 25000000,
  localparam int unsigned CH_IDX_W    = ch_idx_w(NUM_CH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_CH-1:0]   en,
  input  logic                wr_valid,
  input  logic [CH_IDX_W-1:0] wr_ch,
  input  logic [CNT_W-1:0]    wr_half,
`ifdef DIVBANK_SYNC_EN
  input  logic                SYNC,
`endif
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   pending
);

  logic [NUM_CH-1:0] wr_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range indices match no channel and are silently dropped.
    assign wr_sel[i] = wr_valid && (wr_ch == CH_IDX_W'(i));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (CNT_W'(DEFAULT_HALF))
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .en      (en[i]),
      .wr      (wr_sel[i]),
      .wr_half (wr_half),
`ifdef DIVBANK_SYNC_EN
      .sync    (SYNC),
`endif
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: cycle vectors plus reset, out-of-range and sync sequences.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  typedef struct {
    logic [3:0] en;
    logic       wr_valid;
    logic [1:0] wr_ch;
    half_t      wr_half;
    logic [3:0] exp_clk;
    logic [3:0] exp_tick;
    logic [3:0] exp_pend;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] en = '0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_ch = '0;
  half_t      wr_half = '0;
  logic       SYNC = 1'b0;
  logic [3:0] clk_out, tick, pending;

  logic [2:0] s_en = '0;
  logic       s_wr_valid = 1'b0;
  logic [1:0] s_wr_ch = '0;
  logic [7:0] s_wr_half = '0;
  logic [2:0] s_clk_out, s_tick, s_pending;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  clk_div_bank #(.NUM_CH(4), .CNT_W(32), .DEFAULT_HALF(3)) u_dut (
    .CLK(CLK), .RST(RST), .en(en), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_half(wr_half),
`ifdef DIVBANK_SYNC_EN
    .SYNC(SYNC),
`endif
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  // Three channels so that index 3 is out of range.
  clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF(2)) u_small (
    .CLK(CLK), .RST(RST), .en(s_en), .wr_valid(s_wr_valid), .wr_ch(s_wr_ch), .wr_half(s_wr_half),
`ifdef DIVBANK_SYNC_EN
    .SYNC(SYNC),
`endif
    .clk_out(s_clk_out), .tick(s_tick), .pending(s_pending)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] e, input logic wv, input logic [1:0] ch, input int h,
                     input logic [3:0] c, input logic [3:0] t, input logic [3:0] p);
    vec_t v;
    v.en = e; v.wr_valid = wv; v.wr_ch = ch; v.wr_half = half_t'(h);
    v.exp_clk = c; v.exp_tick = t; v.exp_pend = p;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ch0 at default H=3: toggles every 4 cycles
    for (int k = 0; k < 3; k++) add(4'h1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
    for (int k = 0; k < 3; k++) add(4'h1, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
    for (int k = 0; k < 3; k++) add(4'h1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
    // ch0 H=1 written mid-count, applied at the next terminal count
    add(4'h1, 1, 0, 1, 4'b0001, 4'b0000, 4'b0001);
    add(4'h1, 0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
    add(4'h1, 0, 0, 0, 4'b0001, 4'b0000, 4'b0001);
    add(4'h1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    add(4'h1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
    // ch1 H=0 written while disabled, then enabled: CLK/2
    add(4'h1, 1, 1, 0, 4'b0001, 4'b0000, 4'b0010);
    add(4'h1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000);
    add(4'h3, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000);
    add(4'h3, 0, 0, 0, 4'b0001, 4'b0011, 4'b0000);
    add(4'h3, 0, 0, 0, 4'b0011, 4'b0010, 4'b0000);
    add(4'h3, 0, 0, 0, 4'b0000, 4'b0011, 4'b0000);
    // ch2 written twice before its terminal count: H=7 wins
    add(4'h7, 1, 2, 5, 4'b0010, 4'b0010, 4'b0100);
    add(4'h7, 1, 2, 7, 4'b0001, 4'b0011, 4'b0100);
    add(4'h7, 0, 0, 0, 4'b0011, 4'b0010, 4'b0100);
    add(4'h7, 0, 0, 0, 4'b0100, 4'b0111, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0110, 4'b0010, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0101, 4'b0011, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0111, 4'b0010, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0100, 4'b0011, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0110, 4'b0010, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0101, 4'b0011, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0111, 4'b0010, 4'b0000);
    add(4'h7, 0, 0, 0, 4'b0000, 4'b0111, 4'b0000);
    // pending write on ch0 that the following reset must discard
    add(4'h7, 1, 0, 9, 4'b0010, 4'b0010, 4'b0001);

    // reset state
    step();
    step();
    check("reset clk_out", 32'(clk_out), 32'h0);
    check("reset tick", 32'(tick), 32'h0);
    check("reset pending", 32'(pending), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (vecs[i]) begin
      en = vecs[i].en; wr_valid = vecs[i].wr_valid;
      wr_ch = vecs[i].wr_ch; wr_half = vecs[i].wr_half;
      step();
      check($sformatf("vec%0d clk_out", i), 32'(clk_out), 32'(vecs[i].exp_clk));
      check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
      check($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].exp_pend));
      @(negedge CLK);
    end
    wr_valid = 1'b0;

    // asynchronous reset mid-operation, away from any clock edge
    RST = 1'b1;
    #1;
    check("async rst clk_out", 32'(clk_out), 32'h0);
    check("async rst tick", 32'(tick), 32'h0);
    check("async rst pending", 32'(pending), 32'h0);
    en = 4'h1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("post-rst c%0d tick", k), 32'(tick), (k == 4) ? 32'h1 : 32'h0);
      check($sformatf("post-rst c%0d clk_out", k), 32'(clk_out), (k == 4) ? 32'h1 : 32'h0);
      @(negedge CLK);
    end
    en = 4'h0;

    // out-of-range write on the 3-channel instance
    s_en = 3'b001; s_wr_valid = 1'b1; s_wr_ch = 2'd3; s_wr_half = 8'd0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("oor c%0d pending", k), 32'(s_pending), 32'h0);
      check($sformatf("oor c%0d tick", k), 32'(s_tick), (k % 3 == 0) ? 32'h1 : 32'h0);
      check($sformatf("oor c%0d clk_out", k), 32'(s_clk_out), (k >= 3 && k < 6) ? 32'h1 : 32'h0);
      @(negedge CLK);
      s_wr_valid = 1'b0;
    end
    s_en = 3'b000;

`ifdef DIVBANK_SYNC_EN
    // ch0 H=2, ch1 H=4 applied while disabled, run mid-phase, then restart
    wr_valid = 1'b1; wr_ch = 2'd0; wr_half = half_t'(2);
    @(negedge CLK);
    wr_ch = 2'd1; wr_half = half_t'(4);
    @(negedge CLK);
    wr_valid = 1'b0;
    @(negedge CLK);
    check("sync pre pending", 32'(pending), 32'h0);
    en = 4'h3;
    @(negedge CLK);
    @(negedge CLK);
    SYNC = 1'b1;
    step();
    check("sync clk_out", 32'(clk_out), 32'h0);
    check("sync tick", 32'(tick), 32'h0);
    @(negedge CLK);
    SYNC = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("sync c%0d tick", k), 32'(tick),
            32'({(k == 5) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0}));
      @(negedge CLK);
    end
    en = 4'h0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
